// File: rtl/branch_resolver.sv
// Decode-stage branch resolver with an optional 2-bit-counter history table.
// Define BRANCH_RESOLVER_BHT_EN to build the table; otherwise pred_taken is tied 0.
module branch_resolver #(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   f_pc,
    output logic              pred_taken,
    input  logic              d_valid,
    input  logic [PC_W-1:0]   d_pc,
    input  logic [2:0]        d_op,
    input  logic [DATA_W-1:0] d_rs,
    input  logic [DATA_W-1:0] d_rt,
    input  logic              d_pred,
    input  logic              stall,
    output logic              is_branch,
    output logic              mispredict,
    output logic              mispredict_taken
);

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_BEQ  = 3'b001,
        OP_BNE  = 3'b010,
        OP_BLEZ = 3'b011,
        OP_BGTZ = 3'b100,
        OP_BLTZ = 3'b101,
        OP_BGEZ = 3'b110,
        OP_RSVD = 3'b111
    } brOp_t;

    brOp_t op;
    logic  br;
    logic  taken;
    logic  commit;
    logic  rsNeg;
    logic  rsZero;

    assign op     = brOp_t'(d_op);
    assign rsNeg  = d_rs[DATA_W-1];
    assign rsZero = (d_rs == '0);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        br    = 1'b0;
        taken = 1'b0;
        case (op)
            OP_BEQ:  begin br = d_valid; taken = (d_rs == d_rt); end
            OP_BNE:  begin br = d_valid; taken = (d_rs != d_rt); end
            OP_BLEZ: begin br = d_valid; taken = rsNeg || rsZero; end
            OP_BGTZ: begin br = d_valid; taken = !rsNeg && !rsZero; end
            OP_BLTZ: begin br = d_valid; taken = rsNeg; end
            OP_BGEZ: begin br = d_valid; taken = !rsNeg; end
            default: begin br = 1'b0;    taken = 1'b0; end
        endcase
    end

    assign is_branch = br && taken;
    assign commit    = br && !stall;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mispredict       <= 1'b0;
            mispredict_taken <= 1'b0;
        end else begin
            mispredict <= commit && (is_branch != d_pred);
            if (commit) begin
                mispredict_taken <= is_branch;
            end
        end
    end

    // Only index bits feed the table; the rest of each PC is intentionally ignored.
    logic unusedPc;
    assign unusedPc = ^{f_pc, d_pc};

`ifdef BRANCH_RESOLVER_BHT_EN
    localparam int IDX_W = $clog2(BHT_DEPTH);

    typedef enum logic [1:0] {
        SN = 2'b00,
        WN = 2'b01,
        WT = 2'b10,
        ST = 2'b11
    } ctrState_t;

    ctrState_t        bht [BHT_DEPTH];
    ctrState_t        curCtr;
    ctrState_t        nextCtr;
    logic [IDX_W-1:0] fIdx;
    logic [IDX_W-1:0] dIdx;

    assign fIdx   = f_pc[IDX_W+1:2];
    assign dIdx   = d_pc[IDX_W+1:2];
    assign curCtr = bht[dIdx];

    // Read straight from the array: a same-cycle update is not bypassed to the lookup.
    assign pred_taken = (bht[fIdx] == WT) || (bht[fIdx] == ST);

    always_comb begin
        nextCtr = curCtr;
        case (curCtr)
            SN: nextCtr = is_branch ? WN : SN;
            WN: nextCtr = is_branch ? WT : SN;
            WT: nextCtr = is_branch ? ST : WN;
            ST: nextCtr = is_branch ? ST : WT;
            default: nextCtr = WN;
        endcase
    end

    // NOTE: the table is built from flops, so an async reset of every entry is legal here; a RAM macro could not do this.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= WN;
            end
        end else if (commit) begin
            bht[dIdx] <= nextCtr;
        end
    end
`else
    // Table depth only matters when the table is built.
    localparam int unusedBhtDepth = BHT_DEPTH;

    assign pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed steps plus randomized traffic
// compared against a counter-array reference model.
module tb_branch_resolver;

    localparam int DATA_W    = 32;
    localparam int PC_W      = 32;
    localparam int BHT_DEPTH = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [PC_W-1:0]   f_pc;
    logic              pred_taken;
    logic              d_valid;
    logic [PC_W-1:0]   d_pc;
    logic [2:0]        d_op;
    logic [DATA_W-1:0] d_rs;
    logic [DATA_W-1:0] d_rt;
    logic              d_pred;
    logic              stall;
    logic              is_branch;
    logic              mispredict;
    logic              mispredict_taken;

    int errors = 0;
    int checks = 0;

    // Reference state: one saturating count 0..3 per entry, plus expected registered outputs.
    int   ctr [BHT_DEPTH];
    logic expMis;
    logic expMt;

    always #5 clk = ~clk;

    branch_resolver #(
        .DATA_W   (DATA_W),
        .PC_W     (PC_W),
        .BHT_DEPTH(BHT_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .f_pc            (f_pc),
        .pred_taken      (pred_taken),
        .d_valid         (d_valid),
        .d_pc            (d_pc),
        .d_op            (d_op),
        .d_rs            (d_rs),
        .d_rt            (d_rt),
        .d_pred          (d_pred),
        .stall           (stall),
        .is_branch       (is_branch),
        .mispredict      (mispredict),
        .mispredict_taken(mispredict_taken)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic bit refTaken(input logic v, input logic [2:0] op,
                                    input logic [DATA_W-1:0] rs, input logic [DATA_W-1:0] rt);
        int s;
        s = rs;
        if (!v) return 1'b0;
        case (op)
            3'd1:    return rs == rt;
            3'd2:    return rs != rt;
            3'd3:    return s <= 0;
            3'd4:    return s > 0;
            3'd5:    return s < 0;
            3'd6:    return s >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int refIdx(input logic [PC_W-1:0] pc);
        return int'((pc >> 2) % BHT_DEPTH);
    endfunction

    function automatic bit refPred(input logic [PC_W-1:0] pc);
`ifdef BRANCH_RESOLVER_BHT_EN
        return ctr[refIdx(pc)] >= 2;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < BHT_DEPTH; i++) ctr[i] = 1;
        expMis = 1'b0;
        expMt  = 1'b0;
    endfunction

    // One decode cycle: drive at negedge, check combinational outputs, then registered ones after the edge.
    task automatic step(input logic v, input logic [PC_W-1:0] pc, input logic [2:0] op,
                        input logic [DATA_W-1:0] rs, input logic [DATA_W-1:0] rt,
                        input logic pred, input logic stl, input string tag);
        bit tk;
        bit cm;
        int idx;
        @(negedge clk);
        d_valid = v; d_pc = pc; f_pc = pc; d_op = op;
        d_rs = rs; d_rt = rt; d_pred = pred; stall = stl;
        #1;
        tk = refTaken(v, op, rs, rt);
        check({tag, " is_branch"}, is_branch, tk);
        check({tag, " pred_taken"}, pred_taken, refPred(pc));
        cm = v && (op inside {[3'd1:3'd6]}) && !stl;
        @(posedge clk);
        #1;
        expMis = cm && (tk != pred);
        if (cm) begin
            expMt = tk;
            idx = refIdx(pc);
            if (tk && ctr[idx] < 3) ctr[idx]++;
            else if (!tk && ctr[idx] > 0) ctr[idx]--;
        end
        check({tag, " mispredict"}, mispredict, expMis);
        check({tag, " mispredict_taken"}, mispredict_taken, expMt);
    endtask

    task automatic checkPred(input logic [PC_W-1:0] pc, input string tag);
        f_pc = pc;
        #1;
        check({tag, " pred_taken"}, pred_taken, refPred(pc));
    endtask

    initial begin
        logic              v;
        logic              pr;
        logic              stl;
        logic [2:0]        op;
        logic [DATA_W-1:0] rs;
        logic [DATA_W-1:0] rt;
        logic [PC_W-1:0]   pc;

        reset = 1'b1; f_pc = '0; d_valid = 1'b0; d_pc = '0; d_op = 3'd0;
        d_rs = '0; d_rt = '0; d_pred = 1'b0; stall = 1'b0;
        modelReset();
        #1;
        check("reset mispredict", mispredict, 1'b0);
        check("reset mispredict_taken", mispredict_taken, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkPred(32'h0000_0000, "post-reset pc0");
        checkPred(32'h0000_00FC, "post-reset pc-last");

        // beq taken with d_pred=0: mispredict pulse, entry WN->WT
        step(1, 32'h1000, 3'd1, 32'h5, 32'h5, 0, 0, "beq-first");
        checkPred(32'h1000, "beq-first after");
        step(0, 32'h1000, 3'd0, 32'h0, 32'h0, 0, 0, "idle");

        // signed compares at the extremes
        for (int o = 3; o <= 6; o++) step(1, 32'h2000, 3'(o), 32'h8000_0000, 32'h0, 0, 0, "signed-min");
        for (int o = 3; o <= 6; o++) step(1, 32'h2004, 3'(o), 32'h0, 32'hFFFF_FFFF, 1, 0, "signed-zero");
        step(1, 32'h2008, 3'd4, 32'h7FFF_FFFF, 32'h0, 1, 0, "bgtz-max");

        // saturation, decay and aliasing
        repeat (4) step(1, 32'h3000, 3'd1, 32'h9, 32'h9, 1, 0, "sat-up");
        repeat (2) step(1, 32'h3000, 3'd2, 32'h9, 32'h9, 1, 0, "sat-down");
        checkPred(32'h3000, "decayed");
        checkPred(32'h3000 + 4 * BHT_DEPTH, "alias read");
        step(1, 32'h3000 + 4 * BHT_DEPTH, 3'd1, 32'h1, 32'h1, 0, 0, "alias write");
        checkPred(32'h3000, "alias effect");

        // held in stall for three cycles, then released
        repeat (3) step(1, 32'h5000, 3'd1, 32'h3, 32'h3, 0, 1, "stalled");
        step(1, 32'h5000, 3'd1, 32'h3, 32'h3, 0, 0, "unstalled");
        step(0, 32'h5000, 3'd1, 32'h3, 32'h3, 0, 0, "after-unstall");
        checkPred(32'h5000, "stall single step");

        // non-branches with equal operands
        step(1, 32'h6000, 3'd7, 32'h4, 32'h4, 0, 0, "reserved-op");
        step(0, 32'h6000, 3'd1, 32'h4, 32'h4, 0, 0, "invalid");
        step(1, 32'h6000, 3'd0, 32'h4, 32'h4, 1, 0, "op-none");
        checkPred(32'h6000, "no-commit");

        for (int n = 0; n < 300; n++) begin
            v   = ($urandom_range(9) != 0);
            op  = 3'($urandom_range(7));
            case ($urandom_range(3))
                0:       rs = '0;
                1:       rs = 32'h8000_0000 | $urandom;
                2:       rs = 32'($urandom_range(5));
                default: rs = $urandom;
            endcase
            rt  = ($urandom_range(1) != 0) ? rs : $urandom;
            pc  = 32'h4000 + 32'(4 * $urandom_range(15)) + (($urandom_range(1) != 0) ? 32'(4 * BHT_DEPTH) : 32'h0);
            pr  = 1'($urandom_range(1));
            stl = ($urandom_range(3) == 0);
            step(v, pc, op, rs, rt, pr, stl, "random");
        end

        // asynchronous reset mid-stream, away from any clock edge
        step(1, 32'h7000, 3'd1, 32'h2, 32'h2, 0, 0, "pre-reset");
        d_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        check("async mispredict", mispredict, 1'b0);
        check("async mispredict_taken", mispredict_taken, 1'b0);
        check("async is_branch", is_branch, 1'b0);
        for (int i = 0; i < BHT_DEPTH; i++) checkPred(32'(4 * i), "in-reset entry");
        @(negedge clk);
        reset = 1'b0;
        step(1, 32'h0010, 3'd1, 32'h1, 32'h1, 1, 0, "wn-probe");
        checkPred(32'h0010, "wn-probe after");

        // reset raised on the same edge as a pending commit
        @(negedge clk);
        d_valid = 1'b1; d_op = 3'd1; d_rs = 32'h7; d_rt = 32'h7; d_pred = 1'b0;
        stall = 1'b0; d_pc = 32'h2100; f_pc = 32'h2100;
        @(posedge clk);
        reset = 1'b1;
        #1;
        modelReset();
        d_valid = 1'b0;
        check("edge-reset mispredict", mispredict, 1'b0);
        check("edge-reset mispredict_taken", mispredict_taken, 1'b0);
        checkPred(32'h2100, "edge-reset");
        @(negedge clk);
        reset = 1'b0;
        step(1, 32'h2100, 3'd1, 32'h7, 32'h7, 0, 0, "post-edge-reset");
        checkPred(32'h2100, "post-edge-reset after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
